// File: rtl/lsu_unit_if.sv
// Core-side and memory-side handshake bundle of the load/store unit.
// The LSU takes the slave view; the core/memory environment takes the master view.
interface lsu_unit_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Core response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Memory request channel
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;

    // Memory response channel
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;

    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
        input  resp_ready,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready
    );

    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata,
        output resp_ready,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready
    );
endinterface

// File: rtl/lsu_unit.sv
// RV32I load/store unit: one access at a time, lane placement of stores,
// extension of loads, illegal/misaligned detection and a memory-latency timeout.
module lsu_unit #(
    parameter int unsigned MEM_LAT_MAX = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_unit_if.slave bus
);

    // The counter holds 0..MEM_LAT_MAX-1; the last value marks the timeout cycle.
    localparam int unsigned     CNT_W    = (MEM_LAT_MAX < 2) ? 1 : $clog2(MEM_LAT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT_MAX - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic is_legal(input logic wen, input logic [2:0] f3,
                                      input logic [1:0] lo);
        logic legal;
        case (f3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~lo[0];
            F3_W:    legal = (lo == 2'b00);
            F3_BU:   legal = ~wen;
            F3_HU:   legal = ~wen & ~lo[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Selected bytes are brought down to lane 0, then extended to 32 bits.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] raw);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {lo, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   res = {24'h0, sh[7:0]};
            F3_HU:   res = {16'h0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Memory request datapath is driven purely from the latched request, so it
    // stays stable for as long as the REQ state waits on mem_req_ready.
    always_comb begin
        bus.mem_req_wen   = wen_q;
        bus.mem_req_addr  = {addr_q[31:2], 2'b00};
        bus.mem_req_wstrb = 4'b0000;
        bus.mem_req_wdata = 32'h0;
        if (wen_q) begin
            case (funct3_q)
                F3_B: begin
                    bus.mem_req_wstrb = 4'b0001 << addr_q[1:0];
                    bus.mem_req_wdata = {4{wdata_q[7:0]}};
                end
                F3_H: begin
                    bus.mem_req_wstrb = 4'b0011 << addr_q[1:0];
                    bus.mem_req_wdata = {2{wdata_q[15:0]}};
                end
                F3_W: begin
                    bus.mem_req_wstrb = 4'b1111;
                    bus.mem_req_wdata = wdata_q;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        bus.req_ready      = (state_q == S_IDLE);
        bus.mem_req_valid  = (state_q == S_REQ);
        bus.mem_resp_ready = (state_q == S_WAIT);
        bus.resp_valid     = (state_q == S_RESP);
        bus.resp_rdata     = rdata_q;
        bus.resp_err       = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wen_d    = bus.req_wen;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'h0;
                    if (is_legal(bus.req_wen, bus.req_funct3, bus.req_addr[1:0])) begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the final counted cycle still wins over the timeout.
                if (bus.mem_resp_valid) begin
                    rdata_d = wen_q ? 32'h0
                                    : format_load(funct3_q, addr_q[1:0], bus.mem_resp_rdata);
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: rst_n is sampled only on the clock edge, so it stays out of the
    // sensitivity list; all state is cleared, which also abandons any access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wen_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            wen_q    <= wen_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized accesses
// compared against a byte-level reference model.
module tb_lsu_unit;

    localparam int MEM_LAT_MAX = 255;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    lsu_unit_if bus ();

    lsu_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          uses_mem;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          accepted;
        bit          mem_seen;
        bit          mem_stable;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  wstrb;
        logic        mwen;
        int          wcycles;
        bit          got_resp;
        logic [31:0] rdata;
        logic        err;
        bit          resp_stable;
        bit          idle_after;
    } obs_t;

    // Reference model: works in bytes (access size, offset, lane copies).
    function automatic exp_t model(input logic wen, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] mrdata);
        exp_t e;
        int   size;
        int   off;
        bit   sgn;
        bit   ok;
        logic [31:0] v;
        e = '{default: 0};
        ok = 1; size = 1; sgn = 0;
        if (wen) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: ok = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: ok = 0;
            endcase
        end
        off = int'(addr % 4);
        if (ok && (off % size) != 0) ok = 0;
        e.err      = !ok;
        e.uses_mem = ok;
        e.maddr    = addr - (addr % 4);
        if (ok && wen) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + size) e.wstrb[b] = 1'b1;
                e.mwdata[8*b +: 8] = wdata[8*(b % size) +: 8];
            end
        end
        if (ok && !wen) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mrdata[8*(off+i) +: 8];
            if (sgn && v[8*size-1]) for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
        end
        return e;
    endfunction

    // Runs one access through both handshakes and records what was observed.
    // resp_lat < 0 means the memory never answers.
    task automatic drive_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] mrdata,
                             input int req_stall, input int resp_lat, input int resp_stall,
                             output obs_t o);
        o = '{default: 0};
        o.accepted = bus.req_ready;
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        if (bus.mem_req_valid) begin
            o.mem_seen   = 1;
            o.mem_stable = 1;
            o.maddr      = bus.mem_req_addr;
            o.mwdata     = bus.mem_req_wdata;
            o.wstrb      = bus.mem_req_wstrb;
            o.mwen       = bus.mem_req_wen;
            bus.mem_req_ready = 1'b0;
            for (int i = 0; i < req_stall; i++) begin
                @(posedge clk); #1;
                if (!bus.mem_req_valid || bus.mem_req_addr !== o.maddr ||
                    bus.mem_req_wdata !== o.mwdata || bus.mem_req_wstrb !== o.wstrb ||
                    bus.mem_req_wen !== o.mwen)
                    o.mem_stable = 0;
            end
            bus.mem_req_ready = 1'b1;
            @(posedge clk); #1;
            bus.mem_req_ready = 1'b0;
        end
        while (!bus.resp_valid && o.wcycles < MEM_LAT_MAX + 10) begin
            if (o.wcycles == resp_lat) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_rdata = mrdata;
            end
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_rdata = $urandom;
            o.wcycles++;
        end
        if (bus.resp_valid) begin
            o.got_resp    = 1;
            o.rdata       = bus.resp_rdata;
            o.err         = bus.resp_err;
            o.resp_stable = 1;
            bus.resp_ready = 1'b0;
            for (int i = 0; i < resp_stall; i++) begin
                @(posedge clk); #1;
                if (!bus.resp_valid || bus.resp_rdata !== o.rdata || bus.resp_err !== o.err)
                    o.resp_stable = 0;
            end
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
            o.idle_after = !bus.resp_valid && bus.req_ready;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
            bus.mem_resp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got req_ready=%b resp_valid=%b mem_req_valid=%b mem_resp_ready=%b, expected 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.mem_req_valid, bus.mem_resp_ready);
        end
        n_checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got rdata=%h err=%b, expected 00000000 0",
                     bus.resp_rdata, bus.resp_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got req_ready=%b resp_valid=%b, expected 1 0",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        drive_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, o);
        n_checks++;
        if (!o.got_resp || o.rdata !== 32'hFFFF_FF80 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_signext: got resp=%0d rdata=%h err=%b, expected 1 ffffff80 0",
                     o.got_resp, o.rdata, o.err);
        end
        n_checks++;
        if (!o.mem_seen || o.maddr !== 32'h8000_0000 || o.mwen !== 1'b0 || o.wstrb !== 4'b0000) begin
            n_fail++;
            $display("FAIL lb_memreq: got seen=%0d addr=%h wen=%b wstrb=%b, expected 1 80000000 0 0000",
                     o.mem_seen, o.maddr, o.mwen, o.wstrb);
        end
        drive_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 2, 0, o);
        n_checks++;
        if (!o.got_resp || o.rdata !== 32'h0000_BEEF || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL lhu_zeroext: got resp=%0d rdata=%h err=%b, expected 1 0000beef 0",
                     o.got_resp, o.rdata, o.err);
        end
    endtask

    task automatic test_store_half();
        obs_t o;
        drive_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'hFFFF_FFFF, 1, 0, 0, o);
        n_checks++;
        if (o.wstrb !== 4'b1100 || o.mwdata !== 32'hABCD_ABCD || o.maddr !== 32'h8000_0000 ||
            o.mwen !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_lanes: got wstrb=%b wdata=%h addr=%h wen=%b, expected 1100 abcdabcd 80000000 1",
                     o.wstrb, o.mwdata, o.maddr, o.mwen);
        end
        n_checks++;
        if (!o.got_resp || o.rdata !== 32'h0 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_resp: got resp=%0d rdata=%h err=%b, expected 1 00000000 0",
                     o.got_resp, o.rdata, o.err);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        drive_txn(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h1234_5678, 0, 0, 1, o);
        n_checks++;
        if (o.mem_seen || !o.got_resp || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL lw_misaligned: got mem_seen=%0d resp=%0d err=%b rdata=%h, expected 0 1 1 00000000",
                     o.mem_seen, o.got_resp, o.err, o.rdata);
        end
        drive_txn(1'b1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, 0, o);
        n_checks++;
        if (o.mem_seen || o.err !== 1'b1) begin
            n_fail++;
            $display("FAIL store_bad_funct3: got mem_seen=%0d err=%b, expected 0 1",
                     o.mem_seen, o.err);
        end
    endtask

    task automatic test_stall();
        obs_t o;
        exp_t e;
        bit   extra;
        e = model(1'b1, 3'b010, 32'h0000_1234, 32'hCAFE_F00D, 32'h0);
        drive_txn(1'b1, 3'b010, 32'h0000_1234, 32'hCAFE_F00D, 32'h0, 5, 1, 3, o);
        n_checks++;
        if (!o.mem_stable || !o.resp_stable) begin
            n_fail++;
            $display("FAIL stall_stability: got mem_stable=%0d resp_stable=%0d, expected 1 1",
                     o.mem_stable, o.resp_stable);
        end
        n_checks++;
        if (o.wstrb !== e.wstrb || o.mwdata !== e.mwdata || o.maddr !== e.maddr ||
            o.rdata !== e.rdata || o.err !== e.err) begin
            n_fail++;
            $display("FAIL stall_values: got wstrb=%b wdata=%h addr=%h rdata=%h err=%b, expected %b %h %h %h %b",
                     o.wstrb, o.mwdata, o.maddr, o.rdata, o.err,
                     e.wstrb, e.mwdata, e.maddr, e.rdata, e.err);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid || bus.mem_req_valid || !bus.req_ready) extra = 1;
        end
        n_checks++;
        if (!o.idle_after || extra) begin
            n_fail++;
            $display("FAIL stall_single_txn: got idle_after=%0d extra_activity=%0d, expected 1 0",
                     o.idle_after, extra);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 0, -1, 0, o);
        n_checks++;
        if (!o.got_resp || o.wcycles != MEM_LAT_MAX || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout: got resp=%0d wait_cycles=%0d err=%b rdata=%h, expected 1 %0d 1 00000000",
                     o.got_resp, o.wcycles, o.err, o.rdata, MEM_LAT_MAX);
        end
        drive_txn(1'b0, 3'b100, 32'h0000_0041, 32'h0, 32'h0000_9A00, 0, MEM_LAT_MAX - 1, 0, o);
        n_checks++;
        if (!o.got_resp || o.wcycles != MEM_LAT_MAX || o.err !== 1'b0 || o.rdata !== 32'h0000_009A) begin
            n_fail++;
            $display("FAIL late_response: got resp=%0d wait_cycles=%0d err=%b rdata=%h, expected 1 %0d 0 0000009a",
                     o.got_resp, o.wcycles, o.err, o.rdata, MEM_LAT_MAX);
        end
    endtask

    // Everything held asserted: with zero-wait memory an access takes 4 cycles.
    task automatic test_back_to_back();
        exp_t e;
        int   n_resp;
        bit   bad_data;
        e = model(1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_7FFF);
        n_resp = 0; bad_data = 0;
        bus.req_valid      = 1'b1;
        bus.req_wen        = 1'b0;
        bus.req_funct3     = 3'b001;
        bus.req_addr       = 32'h0000_0106;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h8001_7FFF;
        bus.resp_ready     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                n_resp++;
                if (bus.resp_rdata !== e.rdata || bus.resp_err !== 1'b0) bad_data = 1;
            end
        end
        bus.req_valid      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.resp_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (n_resp != 10 || bad_data) begin
            n_fail++;
            $display("FAIL back_to_back: got responses=%0d bad_data=%0d, expected 10 0 (rdata %h)",
                     n_resp, bad_data, e.rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        bit   leaked;
        drive_txn(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, o);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clears_result: got rdata=%h err=%b, expected 00000000 0",
                     bus.resp_rdata, bus.resp_err);
        end
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0300;
        @(posedge clk); #1;
        bus.req_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        n_checks++;
        if (bus.mem_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_wait: got mem_resp_ready=%b, expected 1", bus.mem_resp_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        leaked = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid || !bus.req_ready || bus.mem_resp_ready || bus.mem_req_valid)
                leaked = 1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (leaked) begin
            n_fail++;
            $display("FAIL reset_abandons_access: got stray activity after reset, expected idle (req_ready=%b resp_valid=%b)",
                     bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        for (int i = 0; i < 60; i++) begin
            wen  = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            e = model(wen, f3, addr, wd, rd);
            drive_txn(wen, f3, addr, wd, rd, $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 2), o);
            n_checks++;
            if (!o.got_resp || o.err !== e.err || o.rdata !== e.rdata || !o.idle_after) begin
                n_fail++;
                $display("FAIL rnd_resp[%0d]: wen=%b f3=%0d addr=%h got resp=%0d err=%b rdata=%h, expected 1 %b %h",
                         i, wen, f3, addr, o.got_resp, o.err, o.rdata, e.err, e.rdata);
            end
            n_checks++;
            if (o.mem_seen != e.uses_mem) begin
                n_fail++;
                $display("FAIL rnd_mem_access[%0d]: wen=%b f3=%0d addr=%h got %0d, expected %0d",
                         i, wen, f3, addr, o.mem_seen, e.uses_mem);
            end
            if (e.uses_mem) begin
                n_checks++;
                if (o.maddr !== e.maddr || o.mwen !== wen) begin
                    n_fail++;
                    $display("FAIL rnd_mem_addr[%0d]: got addr=%h wen=%b, expected %h %b",
                             i, o.maddr, o.mwen, e.maddr, wen);
                end
                n_checks++;
                if (o.wstrb !== e.wstrb || (wen && o.mwdata !== e.mwdata)) begin
                    n_fail++;
                    $display("FAIL rnd_lanes[%0d]: f3=%0d addr=%h got wstrb=%b wdata=%h, expected %b %h",
                             i, f3, addr, o.wstrb, o.mwdata, e.wstrb, e.mwdata);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_wen        = 1'b0;
        bus.req_funct3     = 3'b000;
        bus.req_addr       = 32'h0;
        bus.req_wdata      = 32'h0;
        bus.resp_ready     = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h0;
        test_reset();
        test_loads();
        test_store_half();
        test_illegal();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test to complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 SHALL have parameter MEM_LAT_MAX, default 255, meaning the number of WAIT cycles without mem_resp_valid before a timeout error.
REQ-002 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, core load/store request valid.
REQ-005 SHALL have port req_ready, output, 1, LSU accepts a request.
REQ-006 SHALL have port req_wen, input, 1, 1=store, 0=load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width/sign code.
REQ-008 SHALL have port req_addr, input, 32, byte address (ALU result).
REQ-009 SHALL have port req_wdata, input, 32, store data (rs2 value).
REQ-010 SHALL have port resp_valid, output, 1, result available.
REQ-011 SHALL have port resp_ready, input, 1, core consumes result.
REQ-012 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores.
REQ-013 SHALL have port resp_err, output, 1, misaligned, illegal funct3 or timeout.
REQ-014 SHALL have port mem_req_valid / mem_req_ready, output / input, 1 each, memory request handshake.
REQ-015 SHALL have port mem_req_wen, output, 1, memory write enable.
REQ-016 SHALL have port mem_req_addr, output, 32, word-aligned address {req_addr[31:2],2'b00}.
REQ-017 SHALL have port mem_req_wdata / mem_req_wstrb, output, 32 / 4, lane-placed store data and byte strobes.
REQ-018 SHALL have port mem_resp_valid / mem_resp_ready, input / output, 1 each, memory response handshake.
REQ-019 SHALL have port mem_resp_rdata, input, 32, raw word read data.

Function
REQ-020 SHALL implement FSM IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE; mem_req_valid=1 only in REQ; mem_resp_ready=1 only in WAIT; resp_valid=1 only in RESP.
REQ-021 SHALL, in IDLE on req_valid&req_ready, latch wen, funct3, addr and wdata, then go to REQ, or to RESP with resp_err=1 and no memory access if the request is illegal.
REQ-022 SHALL treat loads as legal for funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; stores as legal for 000 SB, 001 SH and 010 SW; every other funct3 is illegal.
REQ-023 SHALL flag as misaligned a halfword with addr[0]=1 and a word with addr[1:0]!=0.
REQ-024 SHALL hold mem_req_* stable in REQ until mem_req_ready, then go to WAIT.
REQ-025 SHALL set wstrb as follows: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111; loads = 4'b0000.
REQ-026 SHALL set wdata as follows: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-027 SHALL, in WAIT on mem_resp_valid, register the formatted result and go to RESP.
REQ-028 SHALL format loads by shifting rdata right by addr[1:0]*8, then sign-extending (LB/LH) or zero-extending (LBU/LHU).
REQ-029 SHALL return resp_rdata=0 for stores.
REQ-030 SHALL count WAIT cycles; when the count reaches MEM_LAT_MAX with no response, SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-031 SHALL hold resp_rdata and resp_err stable while resp_valid=1 and resp_ready=0.
REQ-032 SHALL, on resp_ready in RESP, return to IDLE; no new request is accepted in that same cycle (minimum 4 cycles per legal access with zero-wait memory).
REQ-033 SHALL ignore req_valid outside IDLE and ignore mem_resp_valid outside WAIT.

Reset
REQ-034 SHALL, while rst_n=0 at a clk edge, enter IDLE, clear the latched request, clear the timeout counter, and drive resp_valid=0, resp_err=0, resp_rdata=0, mem_req_valid=0, mem_resp_ready=0 and req_ready=1 on the next cycle.
REQ-035 SHALL abandon an in-flight access on reset and never later assert resp_valid for it.

Verification
REQ-036 SHALL cover: LB at 0x80000003 with mem rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80, resp_err=0.
REQ-037 SHALL cover: LHU at 0x80000002 with rdata 0xBEEF1234 -> resp_rdata 0x0000BEEF.
REQ-038 SHALL cover: SH at 0x80000002 with wdata 0x0000ABCD -> mem_req_wstrb 4'b1100, mem_req_wdata 0xABCDABCD, mem_req_addr 0x80000000, resp_rdata 0.
REQ-039 SHALL cover: LW at 0x80000001 -> resp_err=1 with mem_req_valid never asserted.
REQ-040 SHALL cover: mem_req_ready held low 5 cycles and resp_ready held low 3 cycles -> mem_req_* and resp_* remain stable, and exactly one transaction completes.
REQ-041 SHALL cover: rst_n low during WAIT, then mem_resp_valid pulses -> FSM is in IDLE, resp_valid stays 0 and req_ready=1.
